fp_pack: RTL

Output packer/normalizer for the FP adder datapath. It accepts the unnormalized sign/exponent/extended-mantissa result of the add/subtract stage. It normalizes the mantissa iteratively, one shift per cycle, and rounds to nearest-even. It then packs the result into an IEEE-754 single-precision word behind valid/ready handshakes. It is the inverse of the input unpack stage and is the last stage before the adder result bus.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_pack_if.sv | 27 ++
 rtl/fp_round.sv | 37 +++
 rtl/fp_pack.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared widths, field positions, payload struct and FSM state type for the FP adder output packer.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 28;
  localparam int unsigned EXPI_W = 10;

  localparam int unsigned CARRY_BIT  = 27;
  localparam int unsigned HIDDEN_BIT = 26;
  localparam int unsigned LSB_BIT    = 3;
  localparam int unsigned GUARD_BIT  = 2;
  localparam int unsigned ROUND_BIT  = 1;
  localparam int unsigned STICKY_BIT = 0;

  localparam logic [EXP_W-1:0]  EXP_MAX   = 8'hFF;
  localparam int unsigned       BIAS      = 127;
  localparam logic [FRAC_W-1:0] QNAN_FRAC = 23'h400000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_pack_if.sv
// Handshake bus between the add/subtract stage, the packer and the adder result consumer.
interface fp_pack_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              out_valid;
  logic              out_ready;
  fp32_t             out_result;
  logic              out_overflow;
  logic              out_inexact;

  // Packer side.
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_inexact
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_inexact
  );
endinterface

// File: rtl/fp_round.sv
// Combinational round-to-nearest-even of a normalized mantissa, with exponent fix-up and flags.
module fp_round
  import fp_pkg::*;
(
  input  logic [HIDDEN_BIT:0] mant_i,
  input  logic [EXPI_W-1:0]   exp_i,
  output logic [FRAC_W-1:0]   frac_c_o,
  output logic [EXP_W-1:0]    exp_c_o,
  output logic                overflow_c_o,
  output logic                inexact_c_o
);

  localparam int unsigned SUM_W = HIDDEN_BIT - LSB_BIT + 2;

  logic             inc_c;
  logic             hidden_c;
  logic [SUM_W-1:0] sum_c;
  logic [EXPI_W-1:0] exp_adj_c;

  always_comb begin
    inc_c     = mant_i[GUARD_BIT] & (mant_i[ROUND_BIT] | mant_i[STICKY_BIT] | mant_i[LSB_BIT]);
    sum_c     = {1'b0, mant_i[HIDDEN_BIT:LSB_BIT]} + SUM_W'(inc_c);
    hidden_c  = 1'b1;
    frac_c_o  = sum_c[FRAC_W:1];
    exp_adj_c = exp_i + EXPI_W'(1);
    // No carry out of the increment: hidden bit reflects subnormal-to-normal promotion.
    if (!sum_c[FRAC_W+1]) begin
      frac_c_o  = sum_c[FRAC_W-1:0];
      hidden_c  = sum_c[FRAC_W];
      exp_adj_c = exp_i;
    end
    overflow_c_o = hidden_c & (exp_adj_c >= EXPI_W'(EXP_MAX));
    exp_c_o      = hidden_c ? exp_adj_c[EXP_W-1:0] : '0;
    inexact_c_o  = |mant_i[GUARD_BIT:STICKY_BIT];
  end

endmodule

// File: rtl/fp_pack.sv
// FP adder output stage: iterative normalize, RNE round, IEEE-754 single pack behind valid/ready.
// FP_PACK_DENORM_EN: keep subnormal results; otherwise they flush to signed zero.
module fp_pack
  import fp_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  fp_pack_if.slave  bus
);

  state_e            state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXPI_W-1:0] exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  fp32_t             out_result_q, out_result_d;
  logic              out_overflow_q, out_overflow_d;
  logic              out_inexact_q, out_inexact_d;

  logic [FRAC_W-1:0] rnd_frac_c;
  logic [EXP_W-1:0]  rnd_exp_c;
  logic              rnd_ovf_c;
  logic              rnd_inexact_c;
  logic              accept_c;
  logic              flush_en_c;

`ifdef FP_PACK_DENORM_EN
  assign flush_en_c = 1'b0;
`else
  assign flush_en_c = 1'b1;
`endif

  assign accept_c = bus.in_valid & in_ready_q;

  fp_round u_round (
    .mant_i       (mant_q[HIDDEN_BIT:0]),
    .exp_i        (exp_q),
    .frac_c_o     (rnd_frac_c),
    .exp_c_o      (rnd_exp_c),
    .overflow_c_o (rnd_ovf_c),
    .inexact_c_o  (rnd_inexact_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = (bus.in_exp == EXP_MAX) ? ST_DONE : ST_NORM;
      end
      ST_NORM: begin
        if (mant_q[CARRY_BIT])          state_d = ST_ROUND;
        else if (mant_q == '0)          state_d = ST_DONE;
        else if (mant_q[HIDDEN_BIT])    state_d = ST_ROUND;
        else if (exp_q == EXPI_W'(1))   state_d = ST_ROUND;
      end
      ST_ROUND: state_d = ST_DONE;
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    sign_d         = sign_q;
    exp_d          = exp_q;
    mant_d         = mant_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
    out_inexact_d  = out_inexact_q;
    in_ready_d     = (state_d == ST_IDLE);
    out_valid_d    = (state_q == ST_DONE) && !(out_valid_q && bus.out_ready);
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          sign_d = bus.in_sign;
          exp_d  = (bus.in_exp == '0) ? EXPI_W'(1) : EXPI_W'(bus.in_exp);
          mant_d = bus.in_mant;
          if (bus.in_exp == EXP_MAX) begin
            out_result_d.sign = bus.in_sign;
            out_result_d.exp  = EXP_MAX;
            out_result_d.frac = (bus.in_mant[HIDDEN_BIT-1:LSB_BIT] != '0) ? QNAN_FRAC : '0;
            out_overflow_d    = 1'b0;
            out_inexact_d     = 1'b0;
          end
        end
      end
      ST_NORM: begin
        if (mant_q[CARRY_BIT]) begin
          // Right shift keeps the sticky bit as the OR of everything shifted past it.
          mant_d = {1'b0, mant_q[CARRY_BIT:2], mant_q[ROUND_BIT] | mant_q[STICKY_BIT]};
          exp_d  = exp_q + EXPI_W'(1);
        end else if (mant_q == '0) begin
          out_result_d   = '0;
          out_overflow_d = 1'b0;
          out_inexact_d  = 1'b0;
        end else if (!mant_q[HIDDEN_BIT] && (exp_q != EXPI_W'(1))) begin
          mant_d = {mant_q[CARRY_BIT-1:0], 1'b0};
          exp_d  = exp_q - EXPI_W'(1);
        end
      end
      ST_ROUND: begin
        out_inexact_d  = rnd_inexact_c;
        out_overflow_d = rnd_ovf_c;
        if (rnd_ovf_c) begin
          out_result_d.sign = sign_q;
          out_result_d.exp  = EXP_MAX;
          out_result_d.frac = '0;
        end else if (flush_en_c && (rnd_exp_c == '0)) begin
          out_result_d      = '0;
          out_result_d.sign = sign_q;
          out_inexact_d     = rnd_inexact_c | (rnd_frac_c != '0);
        end else begin
          out_result_d.sign = sign_q;
          out_result_d.exp  = rnd_exp_c;
          out_result_d.frac = rnd_frac_c;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q         <= 1'b0;
      exp_q          <= '0;
      mant_q         <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_inexact_q  <= 1'b0;
    end else begin
      sign_q         <= sign_d;
      exp_q          <= exp_d;
      mant_q         <= mant_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_inexact_q  <= out_inexact_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_inexact  = out_inexact_q;

endmodule
